// File: rtl/div_52x26_quotient.sv
`default_nettype none
// ============================================================================
//  Module      : div_52x26_quotient
//  Description : Iterative restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient
//                and remainder, one quotient bit per clock.
//                Optional macro DIV_OVF_CHECK_EN: early-out with ovf=1 on
//                out-of-range dividend or zero divisor.
//  Revision    : 1.0  initial release
// ============================================================================
module div_52x26_quotient #(
    parameter int WIDTH = 26
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   r,
    output logic               busy,
    output logic               ready,
    output logic               ovf
);

    localparam int            CW          = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_count;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_range_err;

    // The shifted partial remainder keeps its carry bit: rem may be 2^W-1
    // before the shift, so the compare against the divisor needs W+1 bits.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_sub      = w_shift[WIDTH-1:0] - r_div;
    assign w_rem_next = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

`ifdef DIV_OVF_CHECK_EN
    assign w_range_err = (a[2*WIDTH-1:WIDTH] >= b);
`else
    assign w_range_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_count <= '0;
            q       <= '0;
            r       <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == c_last_step) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                        q       <= w_quo_next;
                        r       <= w_rem_next;
                    end
                end
                default: begin
                    // IDLE and DONE both accept, so back-to-back requests see no bubble.
                    if (start) begin
                        r_div   <= b;
                        r_rem   <= a[2*WIDTH-1:WIDTH];
                        r_quo   <= a[WIDTH-1:0];
                        r_count <= '0;
                        ovf     <= w_range_err;
                        if (w_range_err) begin
                            r_state <= S_DONE;
                            ready   <= 1'b1;
                            q       <= '1;
                            r       <= '0;
                        end else begin
                            r_state <= S_RUN;
                            busy    <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_52x26_quotient.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_52x26_quotient
//  Description : Self-checking bench for div_52x26_quotient (vector table,
//                randomized model comparison, multi-cycle corner sequences).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_52x26_quotient;

    localparam int W = 26;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           busy;
    logic           ready;
    logic           ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_52x26_quotient #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .ready (ready),
        .ovf   (ovf)
    );

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; polls ready starting with the current cycle.
    task automatic wait_ready(input int n0, output int lat);
        lat = -1;
        for (int n = n0; n <= 80; n++) begin
            if (ready) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_div(input logic [2*W-1:0] ai, input logic [W-1:0] bi, output int lat);
        start = 1'b1;
        a     = ai;
        b     = bi;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(0, lat);
    endtask

    task automatic count_ready(input int cycles, output int hits);
        hits = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            if (ready) hits++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int             lat;
        int             hits;
        logic [W-1:0]   x, y, lo, hi;
        logic [2*W-1:0] ai;
        logic [63:0]    ea, eb;

        vecs[0] = '{52'd100,                    26'd7,         26'd14,        26'd2};
        vecs[1] = '{52'hFFFFFF8000001,          26'h3FFFFFF,   26'h3FFFFFF,   26'd0};
        vecs[2] = '{52'hFFFFFFBFFFFFF,          26'h3FFFFFF,   26'h3FFFFFF,   26'h3FFFFFE};
        vecs[3] = '{52'd0,                      26'd1,         26'd0,         26'd0};
        vecs[4] = '{52'h3FFFFFF,                26'd1,         26'h3FFFFFF,   26'd0};
        vecs[5] = '{52'd1000000,                26'd1000,      26'd1000,      26'd0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_q", q, 0);
        check("reset_r", r, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", ready, 0);
        check("reset_ovf", ovf, 0);

        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), lat, W);
            check($sformatf("vec%0d_q", i), q, vecs[i].q);
            check($sformatf("vec%0d_r", i), r, vecs[i].r);
        end

        // Product round-trip: (x*y)/y must give back x exactly.
        for (int i = 0; i < 20; i++) begin
            x  = W'($urandom);
            y  = W'($urandom);
            if (y == 0) y = 1;
            ai = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            run_div(ai, y, lat);
            check($sformatf("prod%0d_q", i), q, x);
            check($sformatf("prod%0d_r", i), r, 0);
        end

        // Random in-range operands against plain integer division.
        for (int i = 0; i < 20; i++) begin
            y  = W'($urandom);
            if (y == 0) y = 26'd12345;
            hi = W'($urandom % y);
            lo = W'($urandom);
            ai = {hi, lo};
            ea = {{(64-2*W){1'b0}}, ai};
            eb = {{(64-W){1'b0}}, y};
            run_div(ai, y, lat);
            check($sformatf("rand%0d_latency", i), lat, W);
            check($sformatf("rand%0d_q", i), q, ea / eb);
            check($sformatf("rand%0d_r", i), r, ea % eb);
            check($sformatf("rand%0d_ovf", i), ovf, 0);
        end

        // start mid-RUN with other operands is ignored.
        @(posedge clk); #1;
        start = 1'b1; a = 52'd100; b = 26'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; a = 52'd1000; b = 26'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready(10, lat);
        check("midrun_latency", lat, W);
        check("midrun_q", q, 14);
        check("midrun_r", r, 2);
        count_ready(40, hits);
        check("midrun_no_extra_ready", hits, 0);
        check("midrun_idle_busy", busy, 0);
        check("hold_q_idle", q, 14);
        check("hold_r_idle", r, 2);

        // start held through DONE: second accept with no bubble.
        start = 1'b1; a = vecs[1].a; b = vecs[1].b;
        @(posedge clk); #1;
        wait_ready(0, lat);
        check("b2b_first_latency", lat, W);
        check("b2b_first_q", q, vecs[1].q);
        check("b2b_first_r", r, vecs[1].r);
        a = 52'd100; b = 26'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_second_busy", busy, 1);
        wait_ready(1, lat);
        check("b2b_ready_spacing", lat, W + 1);
        check("b2b_second_q", q, 14);
        check("b2b_second_r", r, 2);

        // Reset at iteration 10 aborts with no ready.
        @(posedge clk); #1;
        start = 1'b1; a = vecs[2].a; b = vecs[2].b;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_q", q, 0);
        rst = 1'b0;
        count_ready(40, hits);
        check("abort_no_ready", hits, 0);
        check("abort_busy_after", busy, 0);

`ifdef DIV_OVF_CHECK_EN
        run_div(52'd5, 26'd0, lat);
        check("ovf_b0_latency", lat, 0);
        check("ovf_b0_flag", ovf, 1);
        check("ovf_b0_q", q, 26'h3FFFFFF);
        check("ovf_b0_r", r, 0);
        run_div({26'd7, 26'd0}, 26'd7, lat);
        check("ovf_edge_latency", lat, 0);
        check("ovf_edge_flag", ovf, 1);
        run_div(52'd100, 26'd7, lat);
        check("ovf_clear_flag", ovf, 0);
        check("ovf_clear_q", q, 14);
`else
        run_div(52'd5, 26'd0, lat);
        check("noovf_b0_latency", lat, W);
        check("noovf_b0_flag", ovf, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
